scarf_logic_capture: RTL and testbench

- SCARF slave (default ID 0x04) on the shared SCARF byte bus alongside the pattern generator, ext SRAM and edge counters.
- Sits directly downstream of the pattern generator. It samples an 8-bit input bus (normally looped back from gpio_pat_gen_out) into an internal DEPTH x 8 buffer.
- Capture is triggered by the rising edge of pattern_active, or by software. The host reads results back over SPI.

---
 rtl/scarf_capture_pkg.sv | 21 ++
 rtl/scarf_capture_buf.sv | 22 ++
 rtl/scarf_logic_capture.sv | 156 +++++++++++++++
 tb/tb_scarf_logic_capture.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scarf_capture_pkg.sv
// rtl/scarf_capture_pkg.sv - shared types and register map for the SCARF logic capture slave
package scarf_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_DIV      = 8'h01;
  localparam logic [7:0] ADDR_STATUS   = 8'h02;
  localparam logic [7:0] ADDR_COUNT    = 8'h03;
  localparam logic [7:0] ADDR_BUF_BASE = 8'h80;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_TRIG_SW = 1;
  localparam int CTRL_CLEAR   = 2;

endpackage

// File: rtl/scarf_capture_buf.sv
// rtl/scarf_capture_buf.sv - DEPTH x 8 capture buffer, one write port, async read port
module scarf_capture_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scarf_logic_capture.sv
// rtl/scarf_logic_capture.sv - SCARF logic capture slave; SCARF_CAPTURE_SYNC_EN adds 2-flop input synchronizers
module scarf_logic_capture
  import scarf_capture_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID = 7'h04,
  parameter int         DEPTH    = 32
) (
  input  logic       clk,
  input  logic       rst_n_sync,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  input  logic       data_in_finished,
  input  logic [6:0] slave_id,
  input  logic       rnw,
  output logic [7:0] read_data_out,
  input  logic [7:0] cap_in,
  input  logic       pattern_active,
  output logic       capture_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0] cap_s;
  logic       pat_s;

`ifdef SCARF_CAPTURE_SYNC_EN
  logic [7:0] cap_m;
  logic       pat_m;
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      cap_m <= '0;
      cap_s <= '0;
      pat_m <= 1'b0;
      pat_s <= 1'b0;
    end else begin
      cap_m <= cap_in;
      cap_s <= cap_m;
      pat_m <= pattern_active;
      pat_s <= pat_m;
    end
  end
`else
  assign cap_s = cap_in;
  assign pat_s = pattern_active;
`endif

  state_t        state;
  logic          sel, data_phase, trig_sw, pat_prev;
  logic [7:0]    ptr, div, div_cnt, buf_rdata, rd_mux, count_rd;
  logic [CW-1:0] count;
  logic          reg_wr, ctrl_wr, arm, clr, pat_rise, sample;

  assign sel      = (slave_id == SLAVE_ID);
  assign reg_wr   = sel & data_in_valid & data_phase & ~rnw;
  assign ctrl_wr  = reg_wr & (ptr == ADDR_CTRL);
  assign arm      = ctrl_wr & data_in[CTRL_ARM];
  assign clr      = ctrl_wr & data_in[CTRL_CLEAR];
  assign pat_rise = pat_s & ~pat_prev;
  assign sample   = ((state == ARMED) & pat_rise) | ((state == CAPTURE) & (div_cnt == 8'd0));

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      data_phase <= 1'b0;
      ptr        <= '0;
      div        <= '0;
      trig_sw    <= 1'b0;
    end else begin
      if (data_in_finished) begin
        data_phase <= 1'b0;
      end else if (sel && data_in_valid) begin
        if (!data_phase) begin
          ptr        <= data_in;
          data_phase <= 1'b1;
        end else begin
          ptr <= ptr + 8'd1;
        end
      end
      if (reg_wr && ptr == ADDR_DIV) div <= data_in;
      if (ctrl_wr) trig_sw <= data_in[CTRL_TRIG_SW];
    end
  end

  // A full 128-deep buffer reports 127 so COUNT stays within the 7-bit index range.
  assign count_rd = (DEPTH == 128 && count == CW'(DEPTH)) ? 8'(DEPTH - 1) : 8'(count);

  always_comb begin
    rd_mux = 8'h00;
    case (ptr)
      ADDR_CTRL:   rd_mux = {6'b0, trig_sw, 1'b0};
      ADDR_DIV:    rd_mux = div;
      ADDR_STATUS: rd_mux = {5'b0, state == DONE, state == CAPTURE, state == ARMED};
      ADDR_COUNT:  rd_mux = count_rd;
      default: if (ptr[7] && int'(ptr[6:0]) < DEPTH) rd_mux = buf_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) read_data_out <= 8'h00;
    else             read_data_out <= (sel && rnw) ? rd_mux : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state        <= IDLE;
      count        <= '0;
      div_cnt      <= '0;
      capture_done <= 1'b0;
      pat_prev     <= 1'b0;
    end else begin
      pat_prev <= pat_s;
      if (clr) begin
        state        <= IDLE;
        count        <= '0;
        capture_done <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (arm) begin
            count        <= '0;
            div_cnt      <= div;
            capture_done <= 1'b0;
            state        <= data_in[CTRL_TRIG_SW] ? CAPTURE : ARMED;
          end
          // The edge cycle itself is stored as sample 0.
          ARMED: if (pat_rise) begin
            count   <= count + CW'(1);
            div_cnt <= div;
            state   <= CAPTURE;
          end
          CAPTURE: begin
            if (div_cnt == 8'd0) begin
              count   <= count + CW'(1);
              div_cnt <= div;
              if (count == CW'(DEPTH - 1)) begin
                state        <= DONE;
                capture_done <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt - 8'd1;
            end
          end
        endcase
      end
    end
  end

  scarf_capture_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (sample & ~clr),
    .waddr (count[AW-1:0]),
    .wdata (cap_s),
    .raddr (ptr[AW-1:0]),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_scarf_logic_capture.sv
// tb/tb_scarf_logic_capture.sv - directed scoreboard bench for scarf_logic_capture
module tb_scarf_logic_capture;

  logic       clk = 1'b0;
  logic       rst_n_sync;
  logic [7:0] data_in;
  logic       data_in_valid, data_in_finished, rnw, pattern_active, capture_done;
  logic [6:0] slave_id;
  logic [7:0] read_data_out, cap_in;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  scarf_logic_capture dut (
    .clk              (clk),
    .rst_n_sync       (rst_n_sync),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_finished (data_in_finished),
    .slave_id         (slave_id),
    .rnw              (rnw),
    .read_data_out    (read_data_out),
    .cap_in           (cap_in),
    .pattern_active   (pattern_active),
    .capture_done     (capture_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    data_in = d;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] d);
    slave_id = 7'h04;
    rnw = 1'b0;
    send(addr);
    send(d);
    data_in_finished = 1'b1;
    @(negedge clk);
    data_in_finished = 1'b0;
  endtask

  task automatic rd(input logic [6:0] id, input logic [7:0] addr, input int n, input string tag);
    slave_id = id;
    rnw = 1'b1;
    send(addr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s scoreboard empty observed=%h", tag, read_data_out);
      end else begin
        chk($sformatf("%s[%0d]", tag, i), read_data_out, exp_q.pop_front());
      end
      if (i < n - 1) send(8'h00);
    end
    data_in_finished = 1'b1;
    @(negedge clk);
    data_in_finished = 1'b0;
    rnw = 1'b0;
  endtask

  // Software trigger with DIV already 0: one sample per clock, base+k in slot k.
  task automatic sw_capture(input logic [7:0] base, input string tag);
    slave_id = 7'h04;
    rnw = 1'b0;
    send(8'h00);
    data_in = 8'h03;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      cap_in = base + 8'(k);
      data_in_finished = (k == 0);
      if (k == 31) chk({tag, "_done_before_last"}, {7'b0, capture_done}, 8'h00);
      @(negedge clk);
    end
    data_in_finished = 1'b0;
    chk({tag, "_done"}, {7'b0, capture_done}, 8'h01);
  endtask

  initial begin
    rst_n_sync = 1'b0;
    data_in = '0; data_in_valid = 0; data_in_finished = 0;
    slave_id = '0; rnw = 0; cap_in = '0; pattern_active = 0;
    repeat (2) @(negedge clk);
    chk("reset_done", {7'b0, capture_done}, 8'h00);
    chk("reset_rdo", read_data_out, 8'h00);
    rst_n_sync = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd(7'h04, 8'h00, 4, "reset_regs");

    // Software trigger, DIV=0
    wr(8'h01, 8'h00);
    sw_capture(8'h10, "sw");
    exp_q.push_back(8'h04); exp_q.push_back(8'd32);
    rd(7'h04, 8'h02, 2, "sw_status_count");
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h10 + 8'(i));
    rd(7'h04, 8'h80, 32, "sw_buf");
    exp_q.push_back(8'h02);
    rd(7'h04, 8'h00, 1, "ctrl_readback");

    // Bus isolation and unmapped address
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd(7'h02, 8'h80, 2, "iso");
    wr(8'h40, 8'hAA);
    exp_q.push_back(8'h00);
    rd(7'h04, 8'h40, 1, "unmapped");
    exp_q.push_back(8'h04); exp_q.push_back(8'd32);
    rd(7'h04, 8'h02, 2, "unmapped_nochange");

    // Pattern trigger, DIV=3
    wr(8'h01, 8'h03);
    wr(8'h00, 8'h01);
    exp_q.push_back(8'h01);
    rd(7'h04, 8'h02, 1, "pat_armed");
    for (int c = 0; c <= 134; c++) begin
      cap_in = 8'h40 + 8'(c);
      pattern_active = (c >= 10);
      if (c == 134) chk("pat_done_before_last", {7'b0, capture_done}, 8'h00);
      @(negedge clk);
    end
    chk("pat_done", {7'b0, capture_done}, 8'h01);
    for (int j = 0; j < 32; j++) exp_q.push_back(8'h4A + 8'(4 * j));
    rd(7'h04, 8'h80, 32, "pat_buf");
    pattern_active = 1'b0;

    // CLEAR during capture; ARM in the same byte must lose
    wr(8'h01, 8'h0F);
    wr(8'h00, 8'h03);
    repeat (112) @(negedge clk);
    exp_q.push_back(8'h02);
    rd(7'h04, 8'h02, 1, "clr_capturing");
    wr(8'h00, 8'h05);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd(7'h04, 8'h02, 2, "clr_status_count");
    chk("clr_done", {7'b0, capture_done}, 8'h00);
    wr(8'h01, 8'h00);
    sw_capture(8'hA0, "rearm");
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    rd(7'h04, 8'h80, 2, "rearm_buf");

    // Reset mid-capture while a STATUS read is driving the bus
    wr(8'h01, 8'h09);
    wr(8'h00, 8'h03);
    repeat (52) @(negedge clk);
    slave_id = 7'h04;
    rnw = 1'b1;
    send(8'h02);
    @(negedge clk);
    chk("midcap_status", read_data_out, 8'h02);
    rst_n_sync = 1'b0;
    #1;
    chk("midcap_rst_rdo", read_data_out, 8'h00);
    chk("midcap_rst_done", {7'b0, capture_done}, 8'h00);
    @(negedge clk);
    rst_n_sync = 1'b1;
    data_in_finished = 1'b1;
    @(negedge clk);
    data_in_finished = 1'b0;
    rnw = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd(7'h04, 8'h02, 2, "midcap_status_count");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
